// File: rtl/rr_stream_mux_if.sv
// Stream bundle for rr_stream_mux: NCH packed input channels and one output stream.
interface rr_stream_mux_if #(
  parameter int WID = 5,
  parameter int NCH = 3
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WID-1:0] in_data;
  logic [NCH-1:0]     in_valid;
  logic [NCH-1:0]     in_ready;
  logic [WID-1:0]     out_data;
  logic [CHW-1:0]     out_ch;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/rr_stream_mux.sv
// Round-robin merge of NCH valid/ready streams into one registered output stage.
module rr_stream_mux #(
  parameter int WID = 5,
  parameter int NCH = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_stream_mux_if.slave  bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CHW-1:0] ptr;
  logic [CHW-1:0] gnt;
  logic           gnt_found;
  logic           load;
  int             idx;

  assign load = ~bus.out_valid | bus.out_ready;

  // Scan starts at ptr and wraps; first valid channel wins.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_found && bus.in_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = CHW'(idx);
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.in_ready[i] = load & gnt_found & (gnt == CHW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
    end else if (load) begin
      if (gnt_found) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.in_data[int'(gnt)*WID +: WID];
        bus.out_ch    <= gnt;
        if (gnt == CHW'(NCH-1)) ptr <= '0;
        else                    ptr <= gnt + 1'b1;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: default 3x5 instance plus 5x8 and 2x5 sweeps.
module tb_rr_stream_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_sw_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   q3[$];
  int   q5[$];
  int   q2[$];

  always #5 clk = ~clk;

  rr_stream_mux_if #(.WID(5), .NCH(3)) b3 ();
  rr_stream_mux_if #(.WID(8), .NCH(5)) b5 ();
  rr_stream_mux_if #(.WID(5), .NCH(2)) b2 ();

  rr_stream_mux #(.WID(5), .NCH(3)) u3 (.clk(clk), .rst_n(rst_n),    .bus(b3));
  rr_stream_mux #(.WID(8), .NCH(5)) u5 (.clk(clk), .rst_n(rst_sw_n), .bus(b5));
  rr_stream_mux #(.WID(5), .NCH(2)) u2 (.clk(clk), .rst_n(rst_sw_n), .bus(b2));

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out3(input string name, input int v, input int d, input int c);
    chk({name, ".valid"}, int'(b3.out_valid), v);
    chk({name, ".data"},  int'(b3.out_data),  d);
    chk({name, ".ch"},    int'(b3.out_ch),    c);
  endtask

  // Monitors: pop one expected {ch,data} per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && b3.out_valid && b3.out_ready) begin
      if (q3.size() == 0) chk("mon3.unexpected", int'(b3.out_ch)*256 + int'(b3.out_data), -1);
      else chk("mon3.word", int'(b3.out_ch)*256 + int'(b3.out_data), q3.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_sw_n && b5.out_valid && b5.out_ready) begin
      chk("mon5.ch_range", int'(b5.out_ch <= 3'd4), 1);
      if (q5.size() == 0) chk("mon5.unexpected", int'(b5.out_ch)*256 + int'(b5.out_data), -1);
      else chk("mon5.word", int'(b5.out_ch)*256 + int'(b5.out_data), q5.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_sw_n && b2.out_valid && b2.out_ready) begin
      if (q2.size() == 0) chk("mon2.unexpected", int'(b2.out_ch)*256 + int'(b2.out_data), -1);
      else chk("mon2.word", int'(b2.out_ch)*256 + int'(b2.out_data), q2.pop_front());
    end
  end

  initial begin
    b3.in_valid = '0; b3.in_data = '0; b3.out_ready = 1'b1;
    b5.in_valid = '0; b5.out_ready = 1'b1;
    b2.in_valid = '0; b2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) b5.in_data[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 2; i++) b2.in_data[i*5 +: 5] = 5'(4 + i);

    // Reset and idle
    tick; tick;
    chk_out3("rst", 0, 0, 0);
    chk("rst.in_ready", int'(b3.in_ready), 0);
    rst_n = 1'b1;
    tick;
    chk_out3("rst_release", 0, 0, 0);

    // Single word from ch1
    b3.in_data = {5'h00, 5'h0A, 5'h00};
    b3.in_valid = 3'b010;
    #1 chk("single.in_ready", int'(b3.in_ready), 3'b010);
    q3.push_back(1*256 + 'h0A);
    tick;
    chk_out3("single.out", 1, 'h0A, 1);
    b3.in_valid = 3'b000;
    tick;
    chk("single.drain", int'(b3.out_valid), 0);

    // Reset pulse so the pointer restarts at ch0
    rst_n = 1'b0; #2 rst_n = 1'b1;

    // Round robin, all valid: ch0=1 ch1=2 ch2=3
    b3.in_data = {5'd3, 5'd2, 5'd1};
    b3.in_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      q3.push_back((k % 3)*256 + (k % 3) + 1);
      tick;
    end
    // Next grant is ch2; make it carry 0x1F and stall on it
    b3.in_data = {5'h1F, 5'd2, 5'd1};
    q3.push_back(2*256 + 'h1F);
    tick;
    b3.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall.in_ready", int'(b3.in_ready), 0);
      chk_out3("stall.hold", 1, 'h1F, 2);
      tick;
    end
    b3.out_ready = 1'b1;
    #1 chk("unstall.in_ready", int'(b3.in_ready), 3'b001);
    q3.push_back(0*256 + 1);
    tick;
    chk_out3("unstall.out", 1, 1, 0);

    // Mid-stream async reset: ch1 word loads, then reset discards it
    tick;
    chk_out3("pre_reset", 1, 2, 1);
    #2 rst_n = 1'b0;
    #1 chk_out3("async_reset", 0, 0, 0);
    tick;
    rst_n = 1'b1;
    q3.push_back(0*256 + 1);
    tick;
    chk_out3("post_reset.first", 1, 1, 0);
    q3.push_back(1*256 + 2);
    tick;
    b3.in_valid = 3'b000;
    tick;
    chk("post_reset.drain", int'(b3.out_valid), 0);

    // Parameter sweep: NCH=5/WID=8 and NCH=2
    rst_sw_n = 1'b1;
    b5.in_valid = 5'b11111;
    b2.in_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      q5.push_back((k % 5)*256 + 'h10 + (k % 5));
      q2.push_back((k % 2)*256 + 4 + (k % 2));
      tick;
    end
    b5.in_valid = '0;
    b2.in_valid = '0;

    for (int w = 0; w < 20 && (q3.size() + q5.size() + q2.size()) != 0; w++) tick;
    chk("q3.empty", q3.size(), 0);
    chk("q5.empty", q5.size(), 0);
    chk("q2.empty", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
